// File: rtl/rng_sequencer_if.sv
// Request/stream bundle between the requester and rng_sequencer.
// master = requesting logic, slave = the sequencer.
interface rng_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             start_i;
   logic [7:0]       count_i;
   logic [WIDTH-1:0] rand_o;
   logic             valid_o;
   logic             ready_i;
   logic             busy_o;
   logic             done_o;
   logic [1:0]       seed_sel_o;

   modport master (
      output start_i,
      output count_i,
      output ready_i,
      input  rand_o,
      input  valid_o,
      input  busy_o,
      input  done_o,
      input  seed_sel_o
   );

   modport slave (
      input  start_i,
      input  count_i,
      input  ready_i,
      output rand_o,
      output valid_o,
      output busy_o,
      output done_o,
      output seed_sel_o
   );
endinterface

// File: rtl/rng_sequencer.sv
// RNG control sequencer: seed pick, LFSR warm-up, burst delivery
// over a valid/ready stream with busy/done status.
module rng_sequencer #(
   parameter int               WIDTH  = 16,
   parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
   parameter int               WARMUP = 8,
   parameter logic [WIDTH-1:0] SEED_0 = 16'hACE1,
   parameter logic [WIDTH-1:0] SEED_1 = 16'h1234,
   parameter logic [WIDTH-1:0] SEED_2 = 16'hBEEF,
   parameter logic [WIDTH-1:0] SEED_3 = 16'h0001
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rng_sequencer_if.slave   bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WARM = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [15:0] WARM_INIT = 16'(WARMUP);

   logic [2:0]       r_state;
   logic [1:0]       r_seed_cnt;
   logic [1:0]       r_seed_sel;
   logic [WIDTH-1:0] r_lfsr;
   logic [7:0]       r_remaining;
   logic [15:0]      r_warm;
   logic             r_valid;

   logic [WIDTH-1:0] w_lfsr_step;
   logic [WIDTH-1:0] w_seed;

   // A zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [WIDTH-1:0] f_seed(input logic [1:0] sel);
      logic [WIDTH-1:0] s;
      unique case (sel)
         2'd0:    s = SEED_0;
         2'd1:    s = SEED_1;
         2'd2:    s = SEED_2;
         default: s = SEED_3;
      endcase
      return (s == '0) ? WIDTH'(1) : s;
   endfunction

   // Galois step: shift right, fold taps in when a 1 falls out.
   always_comb begin
      w_lfsr_step = r_lfsr >> 1;
      if (r_lfsr[0]) begin
         w_lfsr_step = w_lfsr_step ^ TAPS;
      end
      w_seed = f_seed(r_seed_sel);
   end

   // Free-running seed selector, keeps counting while busy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_seed_cnt <= 2'd0;
      end else begin
         r_seed_cnt <= r_seed_cnt + 2'd1;
      end
   end

   // Burst sequencer: IDLE -> LOAD -> WARM -> RUN -> DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_seed_sel  <= 2'd0;
         r_lfsr      <= '0;
         r_remaining <= 8'd0;
         r_warm      <= 16'd0;
         r_valid     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_remaining <= bus.count_i;
                  r_seed_sel  <= r_seed_cnt;
                  if (bus.count_i == 8'd0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               r_lfsr <= w_seed;
               r_warm <= WARM_INIT;
               if (WARM_INIT == 16'd0) begin
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_WARM;
               end
            end
            S_WARM: begin
               r_lfsr <= w_lfsr_step;
               r_warm <= r_warm - 16'd1;
               if (r_warm == 16'd1) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!r_valid) begin
                  r_valid <= 1'b1;
               end else if (bus.ready_i) begin
                  r_lfsr      <= w_lfsr_step;
                  r_remaining <= r_remaining - 8'd1;
                  if (r_remaining == 8'd1) begin
                     r_valid <= 1'b0;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.valid_o    = r_valid;
   assign bus.rand_o     = r_valid ? r_lfsr : '0;
   assign bus.busy_o     = (r_state != S_IDLE);
   assign bus.done_o     = (r_state == S_DONE);
   assign bus.seed_sel_o = r_seed_sel;

endmodule

// File: doc/rng_sequencer.md
# rng_sequencer

Control sequencer for the random number generator. It accepts a start request and picks one of four seeds using a free-running 2-bit seed selector. It then loads and warms up a Galois LFSR, and delivers a requested number of random words over a valid/ready handshake. It sits between the requesting logic (software-facing register block or test engine) and the RNG datapath, and reports busy/done status.

## Interface
- WIDTH, 16, LFSR and output word width (≥ 4)
- TAPS, 16'hB400, Galois feedback mask XORed in when the shifted-out bit is 1
- WARMUP, 8, LFSR steps discarded after seed load (0 allowed = no warm-up)
- SEED_0 / SEED_1 / SEED_2 / SEED_3, 16'hACE1 / 16'h1234 / 16'hBEEF / 16'h0001, seeds indexed by seed_sel_o
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  request a burst; sampled only in IDLE
- count_i  in  8  number of words in the burst; latched with start_i
- rand_o  out  WIDTH  current random word; valid only while valid_o=1
- valid_o  out  1  rand_o holds a word not yet accepted
- ready_i  in  1  consumer accepts rand_o on the edge where valid_o & ready_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a burst completes
- seed_sel_o  out  2  seed index latched for the current or last burst

## Operation
- Free-running 2-bit seed counter: cleared by reset, +1 every edge otherwise (including while busy), wraps 3→0. On an accepted start, seed_sel_o ← counter value at that edge.
- LFSR step: lsb = lfsr[0]; lfsr ← (lfsr >> 1) ^ (lsb ? TAPS : 0).
- Seed load: lfsr ← SEED[seed_sel_o]. A selected seed of 0 loads 1 instead, so the LFSR never locks up.
- FSM states: IDLE, LOAD, WARM, RUN, DONE.
  - IDLE: start_i=1 → latch count_i into remaining and latch seed_sel_o. Go to DONE if count_i=0, else go to LOAD.
  - LOAD: load seed. Go to WARM with warm counter = WARMUP, or go directly to RUN if WARMUP=0.
  - WARM: one LFSR step per cycle. After WARMUP steps → RUN.
  - RUN: valid_o=1 and rand_o=lfsr. On valid_o & ready_i: LFSR steps and remaining decrements. If remaining was 1 → DONE.
  - DONE: done_o=1 for this cycle only → IDLE.
- Backpressure: while valid_o=1 and ready_i=0, rand_o and the LFSR stay frozen.
- start_i outside IDLE is ignored and not queued. A start_i held high in IDLE after DONE begins a new burst.
- Reset at any point (mid-warm-up or mid-burst) aborts immediately; no done_o pulse is produced for the aborted burst.
- Output reset values: rand_o=0, valid_o=0, busy_o=0, done_o=0, seed_sel_o=0. LFSR register=0 and remaining=0.

## Timing
- Let start_i be sampled at edge k. LOAD is active in cycle k..k+1, and the seed is loaded at edge k+1.
- valid_o rises after edge k+2+WARMUP, and the first word equals the seed advanced WARMUP steps.
- With ready_i held high, one word is accepted per cycle. valid_o falls and done_o pulses in the cycle after the last accept.
- count_i=0: busy_o and done_o are high for exactly one cycle (k+1), then the block returns to IDLE with no words issued.
- Minimum turnaround: a new start_i can be accepted on the edge that leaves DONE.

## Test plan
- Reset values: assert rst_i for 3 cycles with random inputs → all outputs 0 and state IDLE. The seed counter then reads 0,1,2,3,0 on consecutive edges.
- Basic burst (WARMUP=0): start_i on the first edge after reset release with count_i=3 and ready_i=1 → seed_sel_o=0. rand_o is 16'hACE1, 16'hE270, 16'h7138 on three consecutive valid cycles, followed by one done_o pulse and busy_o low.
- Backpressure: same stimulus with ready_i low for 4 cycles during the second word → rand_o is held at 16'hE270 and stable for those cycles, then the sequence resumes unchanged.
- Zero count and ignored start: count_i=0 → done_o pulse, no valid_o. Pulsing start_i during RUN → no effect on remaining or seed_sel_o.
- Reset mid-burst: assert rst_i while valid_o=1 after 1 of 5 words → next cycle all outputs are 0 and no done_o. A subsequent start runs a full 5-word burst.
- Warm-up (WARMUP=8): start selecting SEED_3=16'h0001 → first word equals 16'h0001 stepped 8 times, matching the reference model, with valid_o at k+10.
